// File: rtl/sp_ram_arb_pkg.sv
// Shared types and width helpers for the sp_ram round-robin arbiter.
// Holds the requester index type and the outstanding-read sizing.
package sp_ram_arb_pkg;

   // Up to 8 requesters, so a 3-bit index always suffices.
   localparam int REQ_IDX_W = 3;
   typedef logic [REQ_IDX_W-1:0] req_idx_t;

   localparam int DEF_MAX_RD_OUT = 4;
   localparam int DEF_RD_OUT_W   = $clog2(DEF_MAX_RD_OUT);

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int wren_w(input int dw);
      return (dw + 7) / 8;
   endfunction

   // Counter width able to hold the value depth itself.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sp_ram_arb_fifo.sv
// Owner-index FIFO: remembers which requester issued each outstanding read.
// Ports: clkIn, rstIn (async active-low), pushIn/dataIn, popIn, headOut,
// countOut, fullOut, emptyOut. Push and pop in one cycle are both performed.
module sp_ram_arb_fifo
   import sp_ram_arb_pkg::*;
#(
   parameter int DEPTH = DEF_MAX_RD_OUT,
   parameter int WIDTH = REQ_IDX_W,
   localparam int CNT_W = cnt_w(DEPTH)
) (
   input  logic             clkIn,
   input  logic             rstIn,
   input  logic             pushIn,
   input  logic [WIDTH-1:0] dataIn,
   input  logic             popIn,
   output logic [WIDTH-1:0] headOut,
   output logic [CNT_W-1:0] countOut,
   output logic             fullOut,
   output logic             emptyOut
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_cnt;
   logic             w_push;
   logic             w_pop;

   assign fullOut  = (r_cnt == CNT_W'(DEPTH));
   assign emptyOut = (r_cnt == '0);
   assign countOut = r_cnt;
   assign headOut  = r_mem[r_rdPtr];

   assign w_push = pushIn & ~fullOut;
   assign w_pop  = popIn & ~emptyOut;

   // Storage needs no reset; occupancy alone decides validity.
   always_ff @(posedge clkIn) begin
      if (w_push) r_mem[r_wrPtr] <= dataIn;
   end

   always_ff @(posedge clkIn or negedge rstIn) begin
      if (!rstIn) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
         if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
         else if (w_pop && !w_push) r_cnt <= r_cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one sp_ram between NUM_REQ requesters.
// Ports: req*In per requester, gntOut, rdDataOut/rdAckOut, errOut, ram* to RAM.
// Define SP_RAM_ARB_STATS_EN to add gntCntOut (per-requester grant counters).
module sp_ram_arbiter
   import sp_ram_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int RAM_DEPTH  = 512,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_RD_OUT = DEF_MAX_RD_OUT,
   localparam int ADDR_WIDTH = addr_w(RAM_DEPTH),
   localparam int WREN_WIDTH = wren_w(DATA_WIDTH)
) (
   input  logic                          clkIn,
   input  logic                          rstIn,
   input  logic [NUM_REQ-1:0]            reqIn,
   input  logic [NUM_REQ-1:0]            reqWrIn,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddrIn,
   input  logic [NUM_REQ*WREN_WIDTH-1:0] reqWrEnIn,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] reqWrDataIn,
   output logic [NUM_REQ-1:0]            gntOut,
   output logic [DATA_WIDTH-1:0]         rdDataOut,
   output logic [NUM_REQ-1:0]            rdAckOut,
   output logic                          errOut,
   output logic [ADDR_WIDTH-1:0]         ramAddrOut,
   output logic [WREN_WIDTH-1:0]         ramWrEnOut,
   output logic [DATA_WIDTH-1:0]         ramWrDataOut,
   output logic                          ramRdEnOut,
   input  logic [DATA_WIDTH-1:0]         ramRdDataIn,
`ifdef SP_RAM_ARB_STATS_EN
   output logic [NUM_REQ*32-1:0]         gntCntOut,
`endif
   input  logic                          ramRdAckIn
);

   localparam int CNT_W = cnt_w(MAX_RD_OUT);

   req_idx_t               r_last;
   logic [ADDR_WIDTH-1:0]  r_ramAddr;
   logic [WREN_WIDTH-1:0]  r_ramWrEn;
   logic [DATA_WIDTH-1:0]  r_ramWrData;
   logic                   r_ramRdEn;
   logic [DATA_WIDTH-1:0]  r_rdData;
   logic [NUM_REQ-1:0]     r_rdAck;
   logic                   r_err;

   logic [NUM_REQ-1:0]     w_elig;
   logic [2*NUM_REQ-1:0]   w_dbl;
   logic [NUM_REQ-1:0]     w_rot;
   logic [3:0]             w_sh;
   logic [3:0]             w_pos;
   logic                   w_found;
   req_idx_t               w_win;
   logic [NUM_REQ-1:0]     w_gnt;
   logic                   w_wr;
   logic [ADDR_WIDTH-1:0]  w_addr;
   logic [WREN_WIDTH-1:0]  w_be;
   logic [DATA_WIDTH-1:0]  w_data;
   logic                   w_rdOk;
   logic                   w_push;
   logic                   w_pop;
   req_idx_t               w_head;
   logic [CNT_W-1:0]       w_cnt;
   logic                   w_full;
   logic                   w_empty;

   // Reads need a free owner slot; registered occupancy only.
   assign w_rdOk = (w_cnt < CNT_W'(MAX_RD_OUT));
   assign w_elig = reqIn & (reqWrIn | {NUM_REQ{w_rdOk}});

   // Rotate so bit 0 is the requester after lastR.
   // A shift of NUM_REQ wraps back to the unrotated vector.
   assign w_sh  = {1'b0, r_last} + 4'd1;
   assign w_dbl = {w_elig, w_elig} >> w_sh;
   assign w_rot = w_dbl[NUM_REQ-1:0];

   always_comb begin
      w_found = 1'b0;
      w_pos   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_found = 1'b1;
            w_pos   = w_sh + 4'(k);
         end
      end
      if (w_pos >= 4'(NUM_REQ)) w_pos = w_pos - 4'(NUM_REQ);
   end

   assign w_win = w_pos[REQ_IDX_W-1:0];

   always_comb begin
      w_gnt  = '0;
      w_wr   = 1'b0;
      w_addr = '0;
      w_be   = '0;
      w_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_win == REQ_IDX_W'(k)) begin
            w_gnt[k] = w_found;
            w_wr     = reqWrIn[k];
            w_addr   = reqAddrIn[k*ADDR_WIDTH +: ADDR_WIDTH];
            w_be     = reqWrEnIn[k*WREN_WIDTH +: WREN_WIDTH];
            w_data   = reqWrDataIn[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign gntOut = rstIn ? w_gnt : '0;

   assign w_push = w_found & ~w_wr & ~w_full;
   assign w_pop  = ramRdAckIn & ~w_empty;

   sp_ram_arb_fifo #(
      .DEPTH (MAX_RD_OUT),
      .WIDTH (REQ_IDX_W)
   ) u_fifo (
      .clkIn    (clkIn),
      .rstIn    (rstIn),
      .pushIn   (w_push),
      .dataIn   (w_win),
      .popIn    (w_pop),
      .headOut  (w_head),
      .countOut (w_cnt),
      .fullOut  (w_full),
      .emptyOut (w_empty)
   );

   always_ff @(posedge clkIn or negedge rstIn) begin
      if (!rstIn) begin
         r_last      <= req_idx_t'(NUM_REQ - 1);
         r_ramAddr   <= '0;
         r_ramWrEn   <= '0;
         r_ramWrData <= '0;
         r_ramRdEn   <= 1'b0;
         r_rdData    <= '0;
         r_rdAck     <= '0;
         r_err       <= 1'b0;
      end else begin
         r_ramWrEn <= '0;
         r_ramRdEn <= 1'b0;
         r_rdAck   <= '0;
         if (w_found) begin
            r_last      <= w_win;
            r_ramAddr   <= w_addr;
            r_ramWrData <= w_data;
            if (w_wr) r_ramWrEn <= w_be;
            else      r_ramRdEn <= 1'b1;
         end
         // An ack with no owner is dropped and flagged.
         if (ramRdAckIn) begin
            if (w_empty) begin
               r_err <= 1'b1;
            end else begin
               r_rdData <= ramRdDataIn;
               r_rdAck  <= NUM_REQ'(1) << w_head;
            end
         end
      end
   end

   assign ramAddrOut   = r_ramAddr;
   assign ramWrEnOut   = r_ramWrEn;
   assign ramWrDataOut = r_ramWrData;
   assign ramRdEnOut   = r_ramRdEn;
   assign rdDataOut    = r_rdData;
   assign rdAckOut     = r_rdAck;
   assign errOut       = r_err;

`ifdef SP_RAM_ARB_STATS_EN
   logic [NUM_REQ*32-1:0] r_gntCnt;

   always_ff @(posedge clkIn or negedge rstIn) begin
      if (!rstIn) begin
         r_gntCnt <= '0;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (w_found && (w_win == REQ_IDX_W'(k)))
               r_gntCnt[k*32 +: 32] <= r_gntCnt[k*32 +: 32] + 32'd1;
         end
      end
   end

   assign gntCntOut = r_gntCnt;
`endif

endmodule
